// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// The DEMUX_CNT_EN macro adds the per-output delivered-word counters.
package demux_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    // A slot can take a new word if it is empty now or is being drained this cycle.
    function automatic logic slot_can_take(input slot_state_t state, input logic ready);
        return (state == ST_EMPTY) || ready;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output slot of the demux: a single-entry register with EMPTY/FULL FSM.
// With DEMUX_CNT_EN defined the slot also counts delivered words.
//
// state    | meaning
// ST_EMPTY | no word held, valid low, y holds the last delivered word
// ST_FULL  | word held on y, valid high, y stable until drained
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH-1:0]       d,
    input  logic                   ready,
    output logic                   valid,
    output logic [WIDTH-1:0]       y,
    output logic                   can_take
`ifdef DEMUX_CNT_EN
    ,
    input  logic                   cnt_clr,
    output logic [DEMUX_CNT_W-1:0] cnt
`endif
);

    slot_state_t      state;
    slot_state_t      state_next;
    logic [WIDTH-1:0] data_q;
    logic             drain;

    assign valid    = (state == ST_FULL);
    assign drain    = valid && ready;
    assign can_take = slot_can_take(state, ready);
    assign y        = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (load) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                // A load while full only happens together with a drain, so the slot stays full.
                if (drain && !load) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= d;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [DEMUX_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (drain) begin
            cnt_q <= cnt_q + DEMUX_CNT_W'(1);
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 valid/ready stream demultiplexer with one slot per output.
// Defining DEMUX_CNT_EN adds cnt_clr, cnt0 and cnt1 delivered-word counters.
module stream_demux_1to2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       d,
    input  logic                   S,
    output logic                   y0_valid,
    input  logic                   y0_ready,
    output logic [WIDTH-1:0]       y0,
    output logic                   y1_valid,
    input  logic                   y1_ready,
    output logic [WIDTH-1:0]       y1
`ifdef DEMUX_CNT_EN
    ,
    input  logic                   cnt_clr,
    output logic [DEMUX_CNT_W-1:0] cnt0,
    output logic [DEMUX_CNT_W-1:0] cnt1
`endif
);

    logic acc;
    logic load0;
    logic load1;
    logic can_take0;
    logic can_take1;

    // Only the selected slot gates acceptance; a stalled unselected slot never blocks.
    assign in_ready = S ? can_take1 : can_take0;
    assign acc      = in_valid && in_ready;
    assign load0    = acc && !S;
    assign load1    = acc && S;

    demux_out_slot #(
        .WIDTH(WIDTH)
    ) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load0),
        .d       (d),
        .ready   (y0_ready),
        .valid   (y0_valid),
        .y       (y0),
        .can_take(can_take0)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .cnt     (cnt0)
`endif
    );

    demux_out_slot #(
        .WIDTH(WIDTH)
    ) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load1),
        .d       (d),
        .ready   (y1_ready),
        .valid   (y1_valid),
        .y       (y1),
        .can_take(can_take1)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .cnt     (cnt1)
`endif
    );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Self-checking bench for stream_demux_1to2: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_stream_demux_1to2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] d;
    logic        S;
    logic        y0_valid;
    logic        y0_ready;
    logic [31:0] y0;
    logic        y1_valid;
    logic        y1_ready;
    logic [31:0] y1;
`ifdef DEMUX_CNT_EN
    logic        cnt_clr;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_demux_1to2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .d       (d),
        .S       (S),
        .y0_valid(y0_valid),
        .y0_ready(y0_ready),
        .y0      (y0),
        .y1_valid(y1_valid),
        .y1_ready(y1_ready),
        .y1      (y1)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
`endif
    );

    // Reference model: each output is a FIFO of capacity one, plus last-word and counter state.
    logic [31:0] m_q0[$];
    logic [31:0] m_q1[$];
    logic [31:0] m_last0;
    logic [31:0] m_last1;
    int          m_c0;
    int          m_c1;
    int          accepts;

    typedef struct {
        logic        iv;
        logic        s;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        e_ir;
        logic        e_v0;
        logic [31:0] e_y0;
        logic        e_v1;
        logic [31:0] e_y1;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic iv, input logic s, input logic [31:0] dd,
                                input logic r0, input logic r1, input logic e_ir,
                                input logic e_v0, input logic [31:0] e_y0,
                                input logic e_v1, input logic [31:0] e_y1);
        vec_t v;
        v.iv = iv; v.s = s; v.d = dd; v.r0 = r0; v.r1 = r1;
        v.e_ir = e_ir; v.e_v0 = e_v0; v.e_y0 = e_y0; v.e_v1 = e_v1; v.e_y1 = e_y1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q0.delete();
        m_q1.delete();
        m_last0 = '0;
        m_last1 = '0;
        m_c0 = 0;
        m_c1 = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit dr0, dr1, take;
        dr0  = (m_q0.size() != 0) && y0_ready;
        dr1  = (m_q1.size() != 0) && y1_ready;
        take = in_valid && (S ? (m_q1.size() == 0 || y1_ready) : (m_q0.size() == 0 || y0_ready));
        if (dr0) void'(m_q0.pop_front());
        if (dr1) void'(m_q1.pop_front());
        if (take) begin
            accepts++;
            if (S) begin m_q1.push_back(d); m_last1 = d; end
            else   begin m_q0.push_back(d); m_last0 = d; end
        end
`ifdef DEMUX_CNT_EN
        if (cnt_clr) begin
            m_c0 = 0;
            m_c1 = 0;
        end else begin
            m_c0 = (m_c0 + int'(dr0)) % 65536;
            m_c1 = (m_c1 + int'(dr1)) % 65536;
        end
`endif
    endtask

    task automatic model_compare(input string tag);
        logic exp_ir;
        exp_ir = S ? (m_q1.size() == 0 || y1_ready) : (m_q0.size() == 0 || y0_ready);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ir));
        chk({tag, ".y0_valid"}, 32'(y0_valid), 32'(m_q0.size() != 0));
        chk({tag, ".y0"}, y0, (m_q0.size() != 0) ? m_q0[0] : m_last0);
        chk({tag, ".y1_valid"}, 32'(y1_valid), 32'(m_q1.size() != 0));
        chk({tag, ".y1"}, y1, (m_q1.size() != 0) ? m_q1[0] : m_last1);
`ifdef DEMUX_CNT_EN
        chk({tag, ".cnt0"}, 32'(cnt0), 32'(m_c0));
        chk({tag, ".cnt1"}, 32'(cnt1), 32'(m_c1));
`endif
    endtask

    // Compare just before the edge, step the model, then land 1 time unit after the edge.
    task automatic tick(input string tag);
        @(negedge clk);
        model_compare(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic iv, input logic s, input logic [31:0] dd,
                          input logic r0, input logic r1);
        in_valid = iv; S = s; d = dd; y0_ready = r0; y1_ready = r1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #12;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
`ifdef DEMUX_CNT_EN
        cnt_clr = 1'b0;
`endif
        accepts = 0;
        rst_n = 1'b0;
        model_clear();
        #2;
        chk("reset.y0_valid", 32'(y0_valid), 0);
        chk("reset.y1_valid", 32'(y1_valid), 0);
        chk("reset.y0", y0, 0);
        chk("reset.y1", y1, 0);
        chk("reset.in_ready", 32'(in_ready), 1);
        do_reset();

        // Directed table: select 0, select 1, stall, independence, resume without gap.
        vecs[0]  = mk(1, 0, 32'hAAAAAAAA, 0, 0,  1, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 0,  1, 1, 32'hAAAAAAAA, 0, 32'h0);
        vecs[2]  = mk(1, 1, 32'h55555555, 0, 1,  1, 0, 32'hAAAAAAAA, 0, 32'h0);
        vecs[3]  = mk(0, 1, 32'h0,        0, 1,  1, 0, 32'hAAAAAAAA, 1, 32'h55555555);
        vecs[4]  = mk(1, 0, 32'h12345678, 0, 0,  1, 0, 32'hAAAAAAAA, 0, 32'h55555555);
        vecs[5]  = mk(1, 0, 32'h87654321, 0, 0,  0, 1, 32'h12345678, 0, 32'h55555555);
        vecs[6]  = mk(1, 0, 32'h87654321, 0, 0,  0, 1, 32'h12345678, 0, 32'h55555555);
        vecs[7]  = mk(1, 1, 32'hDEADBEEF, 0, 0,  1, 1, 32'h12345678, 0, 32'h55555555);
        vecs[8]  = mk(1, 0, 32'h87654321, 1, 0,  1, 1, 32'h12345678, 1, 32'hDEADBEEF);
        vecs[9]  = mk(0, 0, 32'h0,        1, 1,  1, 1, 32'h87654321, 1, 32'hDEADBEEF);
        vecs[10] = mk(0, 0, 32'h0,        0, 0,  1, 0, 32'h87654321, 0, 32'hDEADBEEF);

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].iv, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1);
            @(negedge clk);
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d.y0_valid", i), 32'(y0_valid), 32'(vecs[i].e_v0));
            chk($sformatf("vec%0d.y0", i), y0, vecs[i].e_y0);
            chk($sformatf("vec%0d.y1_valid", i), 32'(y1_valid), 32'(vecs[i].e_v1));
            chk($sformatf("vec%0d.y1", i), y1, vecs[i].e_y1);
            model_step();
            @(posedge clk);
            #1;
        end

        // Streaming: 8 words alternating S with both consumers ready, then drain.
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'(i % 2), 32'hC0DE_0000 + 32'(i), 1'b1, 1'b1);
            tick($sformatf("stream%0d", i));
        end
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b1);
        tick("stream_tail");
        tick("stream_idle");
        chk("stream.accepts", 32'(accepts), 8);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(),
                   1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
`ifdef DEMUX_CNT_EN
            cnt_clr = ($urandom_range(0, 40) == 0);
`endif
            tick("rand");
        end
`ifdef DEMUX_CNT_EN
        cnt_clr = 1'b0;
`endif

        // Reset mid-operation with both slots full: outputs clear without an edge.
        set_in(1'b1, 1'b0, 32'h0F0F0F0F, 1'b0, 1'b0);
        tick("fill0");
        set_in(1'b1, 1'b1, 32'hF0F0F0F0, 1'b0, 1'b0);
        tick("fill1");
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("prerst.y0_valid", 32'(y0_valid), 1);
        chk("prerst.y1_valid", 32'(y1_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.y0_valid", 32'(y0_valid), 0);
        chk("midrst.y1_valid", 32'(y1_valid), 0);
        chk("midrst.y0", y0, 0);
        chk("midrst.y1", y1, 0);
        chk("midrst.in_ready", 32'(in_ready), 1);
`ifdef DEMUX_CNT_EN
        chk("midrst.cnt0", 32'(cnt0), 0);
        chk("midrst.cnt1", 32'(cnt1), 0);
`endif
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("postrst");

`ifdef DEMUX_CNT_EN
        // Preload cnt0 to 0xFFFF by streaming into output 0, then wrap on one more drain.
        begin
            int guard;
            guard = 0;
            set_in(1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
            while (m_c0 != 16'hFFFF && guard < 70000) begin
                @(negedge clk);
                model_step();
                @(posedge clk);
                #1;
                d = d + 32'd1;
                guard++;
            end
            if (guard >= 70000) begin
                checks++;
                errors++;
                $display("FAIL preload_bound actual=%0d required=%0d", m_c0, 16'hFFFF);
            end
        end
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("preload.cnt0", 32'(cnt0), 32'hFFFF);
        tick("wrap_drain");
        chk("wrap.cnt0", 32'(cnt0), 0);
        set_in(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
        tick("clr_load_a");
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
        tick("clr_drain_a");
        chk("clr.pre_cnt0", 32'(cnt0), 1);
        set_in(1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
        tick("clr_load_b");
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cnt_clr = 1'b1;
        tick("clr_drain_b");
        cnt_clr = 1'b0;
        chk("clr_wins.cnt0", 32'(cnt0), 0);
        tick("clr_after");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
